// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM encoding and frame timing constants for the UART receive sequencer
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START_CHK = 2'd1,
    ST_BITS      = 2'd2,
    ST_COMMIT    = 2'd3
  } rx_state_e;

  // Oversample ticks per bit, ticks to the middle of the start bit, strobes per frame
  localparam int OS_RATE   = 16;
  localparam int START_MID = 8;
  localparam int N_STROBES = 11;

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - small receive FIFO with wrap-bit pointers and a registered head
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      rd_next;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign pop_ok  = pop && !empty;
  // A push into a full FIFO still lands when the same cycle frees a slot
  assign push_ok = push && (!full || pop_ok);
  assign rd_next = rd_ptr + {{AW{1'b0}}, pop_ok};

  // Storage array; cleared on reset so stale data never reappears
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Pointers and registered head; bypass the write data when it becomes the new head
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      head   <= '0;
    end else begin
      wr_ptr <= wr_ptr + {{AW{1'b0}}, push_ok};
      rd_ptr <= rd_next;
      if (push_ok && (rd_next == wr_ptr)) head <= push_data;
      else                                head <= mem[rd_next[AW-1:0]];
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - start-bit qualification, bit strobing and result commit for uart_rx
module uart_rx_ctrl #(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             rx_in,
  output logic             rx_sync,
  output logic             bclk_rx,
  output logic             rx_rst_n,
  input  logic [7:0]       d_out_rx,
  input  logic             p_error,
  input  logic             stop_error,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             overrun,
  output logic [CNT_W-1:0] par_err_cnt,
  output logic [CNT_W-1:0] frm_err_cnt,
  input  logic             clr_err
);

  import uart_pkg::*;

  rx_state_e        state;
  logic             sync1;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] os_cnt;
  logic [3:0]       os_idx;
  logic [3:0]       bit_cnt;
  logic             os_tick;
  logic             abort;
  logic             commit;
  logic             commit_good;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;

  assign os_tick     = (os_cnt == '0);
  assign abort       = !en && (state != ST_IDLE);
  assign commit      = (state == ST_COMMIT) && en;
  assign commit_good = commit && !p_error && !stop_error;
  assign pop         = rx_valid && rx_ready;
  assign rx_valid    = !fifo_empty;

  // Two-flop synchroniser; the line idles high
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      sync1   <= rx_in;
      rx_sync <= sync1;
    end
  end

  // Receiver reset pulses low for one cycle on an abort
  always_ff @(posedge clk) begin
    rx_rst_n <= !(reset || abort);
  end

  // Frame sequencer: prescaler, start-bit check, mid-bit strobes, commit slot
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      div_q   <= '0;
      os_cnt  <= '0;
      os_idx  <= '0;
      bit_cnt <= '0;
      bclk_rx <= 1'b0;
    end else begin
      bclk_rx <= 1'b0;
      if (abort) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (en && !rx_sync) begin
              div_q  <= baud_div;
              os_cnt <= baud_div;
              os_idx <= '0;
              state  <= ST_START_CHK;
            end
          end
          ST_START_CHK: begin
            os_cnt <= os_tick ? div_q : os_cnt - DIV_W'(1);
            if (os_tick) begin
              if (os_idx == 4'(START_MID - 1)) begin
                if (rx_sync) begin
                  state <= ST_IDLE;
                end else begin
                  bclk_rx <= 1'b1;
                  os_idx  <= '0;
                  bit_cnt <= '0;
                  state   <= ST_BITS;
                end
              end else begin
                os_idx <= os_idx + 4'd1;
              end
            end
          end
          ST_BITS: begin
            // Stay one cycle past the stop strobe so uart_rx outputs settle before COMMIT
            if (bit_cnt == 4'(N_STROBES - 1)) begin
              state <= ST_COMMIT;
            end else begin
              os_cnt <= os_tick ? div_q : os_cnt - DIV_W'(1);
              if (os_tick) begin
                if (os_idx == 4'(OS_RATE - 1)) begin
                  os_idx  <= '0;
                  bclk_rx <= 1'b1;
                  bit_cnt <= bit_cnt + 4'd1;
                end else begin
                  os_idx <= os_idx + 4'd1;
                end
              end
            end
          end
          ST_COMMIT: state <= ST_IDLE;
          default:   state <= ST_IDLE;
        endcase
      end
    end
  end

  // Error counters and sticky overrun; clr_err wins over any same-cycle update
  always_ff @(posedge clk) begin
    if (reset || clr_err) begin
      par_err_cnt <= '0;
      frm_err_cnt <= '0;
      overrun     <= 1'b0;
    end else if (commit) begin
      if (p_error) begin
        if (par_err_cnt != '1) par_err_cnt <= par_err_cnt + CNT_W'(1);
      end else if (stop_error) begin
        if (frm_err_cnt != '1) frm_err_cnt <= frm_err_cnt + CNT_W'(1);
      end else if (fifo_full && !pop) begin
        overrun <= 1'b1;
      end
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (commit_good),
    .push_data (d_out_rx),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (rx_data)
  );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - self-checking bench for uart_rx_ctrl with a stand-in bit receiver
module tb_uart_rx_ctrl;

  localparam int DIV_W      = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic [DIV_W-1:0] baud_div;
  logic             rx_in;
  logic             rx_sync;
  logic             bclk_rx;
  logic             rx_rst_n;
  logic [7:0]       d_out_rx = 8'h00;
  logic             p_error = 1'b0;
  logic             stop_error = 1'b0;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             overrun;
  logic [CNT_W-1:0] par_err_cnt;
  logic [CNT_W-1:0] frm_err_cnt;
  logic             clr_err;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.DIV_W(DIV_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .en(en), .baud_div(baud_div), .rx_in(rx_in),
    .rx_sync(rx_sync), .bclk_rx(bclk_rx), .rx_rst_n(rx_rst_n),
    .d_out_rx(d_out_rx), .p_error(p_error), .stop_error(stop_error),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .overrun(overrun), .par_err_cnt(par_err_cnt), .frm_err_cnt(frm_err_cnt),
    .clr_err(clr_err)
  );

  // Stand-in for uart_rx: captures the line on each strobe, even parity, reports after the stop bit
  logic [10:0] ur_bits = '0;
  int          ur_idx = 0;
  always @(posedge clk) begin
    if (!rx_rst_n) begin
      ur_idx <= 0;
    end else if (bclk_rx) begin
      ur_bits[ur_idx] <= rx_sync;
      if (ur_idx == 10) begin
        ur_idx     <= 0;
        d_out_rx   <= ur_bits[8:1];
        p_error    <= ^ur_bits[9:1];
        stop_error <= !rx_sync;
      end else begin
        ur_idx <= ur_idx + 1;
      end
    end
  end

  // Observation of strobes, valid rise and receiver-reset pulses, sampled mid-cycle
  int cyc = 0, strobe_cnt = 0, last_strobe = -1, min_gap = 1000000, max_gap = 0;
  int consec = 0, rstn_low = 0, rise_cyc = -1;
  bit prev_b = 1'b0, prev_v = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (bclk_rx) begin
      strobe_cnt++;
      if (prev_b) consec++;
      if (last_strobe >= 0) begin
        if (cyc - last_strobe < min_gap) min_gap = cyc - last_strobe;
        if (cyc - last_strobe > max_gap) max_gap = cyc - last_strobe;
      end
      last_strobe = cyc;
    end
    if (rx_valid && !prev_v) rise_cyc = cyc;
    if (!reset && !rx_rst_n) rstn_low++;
    prev_b = bclk_rx;
    prev_v = rx_valid;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Drive one frame LSB first, then one idle bit time
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int div);
    logic [10:0] f;
    f = {stop, par, d, 1'b0};
    baud_div = div[DIV_W-1:0];
    for (int i = 0; i < 11; i++) begin
      rx_in = f[i];
      repeat (16 * (div + 1)) @(negedge clk);
    end
    rx_in = 1'b1;
    repeat (16 * (div + 1)) @(negedge clk);
  endtask

  // Reference model: even parity, parity error outranks framing error, FIFO_DEPTH-entry queue
  logic [7:0] mq[$];
  int m_perr = 0, m_ferr = 0;
  bit m_ovr = 1'b0;

  function automatic void model_frame(input logic [7:0] d, input logic par, input logic stop);
    if ((^d) != par) begin
      if (m_perr < (1 << CNT_W) - 1) m_perr++;
    end else if (!stop) begin
      if (m_ferr < (1 << CNT_W) - 1) m_ferr++;
    end else if (mq.size() == FIFO_DEPTH) begin
      m_ovr = 1'b1;
    end else begin
      mq.push_back(d);
    end
  endfunction

  task automatic check_model(input string tag);
    chk({tag, "_valid"}, 32'(rx_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) chk({tag, "_data"}, 32'(rx_data), 32'(mq[0]));
    chk({tag, "_perr"}, 32'(par_err_cnt), 32'(m_perr));
    chk({tag, "_ferr"}, 32'(frm_err_cnt), 32'(m_ferr));
    chk({tag, "_ovr"}, 32'(overrun), 32'(m_ovr));
  endtask

  task automatic pop_pulse();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    chk({tag, "_pop_valid"}, 32'(rx_valid), 32'd1);
    chk({tag, "_pop_data"}, 32'(rx_data), 32'(mq[0]));
    void'(mq.pop_front());
    pop_pulse();
  endtask

  task automatic clear_all();
    for (int k = 0; k < 2 * FIFO_DEPTH; k++) if (rx_valid) pop_pulse();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    mq.delete();
    m_perr = 0;
    m_ferr = 0;
    m_ovr  = 1'b0;
    chk("clear_state", {29'd0, rx_valid, overrun, |{par_err_cnt, frm_err_cnt}}, 32'd0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_perr;
    int         exp_ferr;
  } vec_t;

  vec_t       tbl [8];
  int         s0, r0;
  bit         got;
  logic [7:0] rd;
  logic       rp, rs;

  initial begin
    tbl[0] = '{8'h55, 1'b0, 1'b1, 1'b1, 8'h55, 0, 0};
    tbl[1] = '{8'h80, 1'b1, 1'b1, 1'b1, 8'h80, 0, 0};
    tbl[2] = '{8'h80, 1'b0, 1'b1, 1'b0, 8'h00, 1, 0};
    tbl[3] = '{8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 1, 1};
    tbl[4] = '{8'h07, 1'b0, 1'b0, 1'b0, 8'h00, 2, 1};
    tbl[5] = '{8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 2, 1};
    tbl[6] = '{8'hC3, 1'b0, 1'b1, 1'b1, 8'hC3, 2, 1};
    tbl[7] = '{8'hFE, 1'b0, 1'b0, 1'b0, 8'h00, 3, 1};

    reset = 1'b1; en = 1'b1; rx_in = 1'b1; baud_div = 16'd3; rx_ready = 1'b0; clr_err = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_rx_sync", 32'(rx_sync), 32'd1);
    chk("rst_bclk", 32'(bclk_rx), 32'd0);
    chk("rst_rx_rst_n", 32'(rx_rst_n), 32'd0);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_data", 32'(rx_data), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_cnts", 32'({par_err_cnt, frm_err_cnt}), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_release_rx_rst_n", 32'(rx_rst_n), 32'd1);
    repeat (10) @(negedge clk);

    // Good frame 0xA5 at baud_div=3: 11 strobes 64 clk apart, visible two cycles after stop strobe
    s0 = strobe_cnt; last_strobe = -1; min_gap = 1000000; max_gap = 0;
    send_frame(8'hA5, 1'b0, 1'b1, 3);
    chk("a5_strobes", 32'(strobe_cnt - s0), 32'd11);
    chk("a5_min_gap", 32'(min_gap), 32'd64);
    chk("a5_max_gap", 32'(max_gap), 32'd64);
    chk("a5_latency", 32'(rise_cyc - last_strobe), 32'd2);
    chk("a5_valid", 32'(rx_valid), 32'd1);
    chk("a5_data", 32'(rx_data), 32'hA5);
    chk("a5_cnts", 32'({par_err_cnt, frm_err_cnt}), 32'd0);
    pop_pulse();

    // Start-bit glitch: 20 clk low is rejected at the mid-start check
    s0 = strobe_cnt; r0 = rstn_low;
    rx_in = 1'b0;
    repeat (20) @(negedge clk);
    rx_in = 1'b1;
    repeat (100) @(negedge clk);
    chk("glitch_strobes", 32'(strobe_cnt - s0), 32'd0);
    chk("glitch_rstn", 32'(rstn_low - r0), 32'd0);
    chk("glitch_valid", 32'(rx_valid), 32'd0);

    // Parity error then framing error
    send_frame(8'h01, 1'b0, 1'b1, 3);
    chk("perr_cnt", 32'(par_err_cnt), 32'd1);
    chk("perr_valid", 32'(rx_valid), 32'd0);
    send_frame(8'h01, 1'b1, 1'b0, 3);
    chk("ferr_cnt", 32'(frm_err_cnt), 32'd1);
    chk("ferr_perr_cnt", 32'(par_err_cnt), 32'd1);

    // Five good frames into a four-entry FIFO with no pops
    clear_all();
    for (int i = 0; i < 5; i++) begin
      rd = 8'h10 + 8'(i);
      send_frame(rd, ^rd, 1'b1, 0);
    end
    chk("ovr_flag", 32'(overrun), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("ovr_pop_valid", 32'(rx_valid), 32'd1);
      chk("ovr_pop_data", 32'(rx_data), 32'h10 + 32'(i));
      pop_pulse();
    end
    chk("ovr_empty", 32'(rx_valid), 32'd0);

    // Abort after strobe 4, then a clean frame
    clear_all();
    s0 = strobe_cnt; r0 = rstn_low; got = 1'b0;
    fork
      send_frame(8'h5A, 1'b0, 1'b1, 3);
      begin
        for (int k = 0; k < 1000; k++) begin
          @(posedge clk);
          if (strobe_cnt >= s0 + 5) begin
            got = 1'b1;
            break;
          end
        end
        @(negedge clk);
        en = 1'b0;
      end
    join
    en = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_wait", 32'(got), 32'd1);
    chk("abort_strobes", 32'(strobe_cnt - s0), 32'd5);
    chk("abort_rstn_pulse", 32'(rstn_low - r0), 32'd1);
    chk("abort_valid", 32'(rx_valid), 32'd0);
    chk("abort_cnts", 32'({par_err_cnt, frm_err_cnt}), 32'd0);
    send_frame(8'h3C, 1'b0, 1'b1, 3);
    chk("post_abort_valid", 32'(rx_valid), 32'd1);
    chk("post_abort_data", 32'(rx_data), 32'h3C);
    chk("post_abort_cnts", 32'({par_err_cnt, frm_err_cnt}), 32'd0);

    // Table of classified frames at baud_div=0
    clear_all();
    for (int i = 0; i < 8; i++) begin
      send_frame(tbl[i].data, tbl[i].par, tbl[i].stop, 0);
      chk($sformatf("tbl%0d_valid", i), 32'(rx_valid), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) chk($sformatf("tbl%0d_data", i), 32'(rx_data), 32'(tbl[i].exp_data));
      chk($sformatf("tbl%0d_perr", i), 32'(par_err_cnt), 32'(tbl[i].exp_perr));
      chk($sformatf("tbl%0d_ferr", i), 32'(frm_err_cnt), 32'(tbl[i].exp_ferr));
      if (rx_valid) pop_pulse();
    end

    // Random frames against the reference model, with random host pops between frames
    clear_all();
    for (int i = 0; i < 24; i++) begin
      rd = 8'($urandom);
      rp = (^rd) ^ ($urandom_range(0, 4) == 0);
      rs = ($urandom_range(0, 5) != 0);
      send_frame(rd, rp, rs, 0);
      model_frame(rd, rp, rs);
      check_model($sformatf("rnd%0d", i));
      for (int k = $urandom_range(0, 2); k > 0; k--) if (mq.size() != 0) pop_check($sformatf("rnd%0d", i));
    end

    // Saturation of the parity counter and clear
    clear_all();
    for (int i = 0; i < 300; i++) send_frame(8'h01, 1'b0, 1'b1, 0);
    chk("sat_perr", 32'(par_err_cnt), 32'hFF);
    chk("sat_ferr", 32'(frm_err_cnt), 32'd0);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("clr_perr", 32'(par_err_cnt), 32'd0);
    chk("clr_overrun", 32'(overrun), 32'd0);

    chk("bclk_never_back_to_back", 32'(consec), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
